// File: rtl/dcache_arb_pkg.sv
// Shared types and constants for the dcache request arbiter.
package dcache_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    int unsigned idx;

    // Scan NUM_REQ slots starting at ptr; the first hit wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req[idx[PW-1:0]]) begin
                any    = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing one dcache request/response port between
// NUM_REQ requesters, one transaction outstanding, with optional timeout.
module dcache_req_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned WORD_SIZE      = 8,
    parameter int unsigned ADDR_LENGTH    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             r_req_valid,
    input  logic [NUM_REQ*ADDR_LENGTH-1:0] r_req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   r_req_wdata,
    input  logic [NUM_REQ-1:0]             r_req_write,
    input  logic [NUM_REQ*3-1:0]           r_req_size,
    output logic [NUM_REQ-1:0]             r_req_ready,
    output logic [NUM_REQ-1:0]             r_resp_valid,
    output logic [WORD_SIZE-1:0]           r_resp_rdata,
    output logic                           r_resp_err,
    output logic                           c_req_valid,
    output logic [ADDR_LENGTH-1:0]         c_req_addr,
    output logic [WORD_SIZE-1:0]           c_req_wdata,
    output logic                           c_req_write,
    output logic [2:0]                     c_req_size,
    input  logic                           c_req_ready,
    input  logic                           c_resp_valid,
    input  logic [WORD_SIZE-1:0]           c_resp_rdata,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

    localparam int unsigned GW    = $clog2(NUM_REQ);
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    localparam int unsigned TW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_t             state;
    logic [GW-1:0]          rr_ptr;
    logic [ADDR_LENGTH-1:0] hold_addr;
    logic [WORD_SIZE-1:0]   hold_wdata;
    logic                   hold_write;
    logic [2:0]             hold_size;
    logic [TW-1:0]          timer;

    logic                   pick_any;
    logic [GW-1:0]          pick_idx;
    logic                   resp_ok;
    logic                   resp_to;
    logic [NUM_REQ-1:0]     owner_oh;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (r_req_valid),
        .ptr    (rr_ptr),
        .any    (pick_any),
        .winner (pick_idx)
    );

    // Accept pulse and response routing are combinational so a response costs
    // no extra cycle; the accept pulse is forced low while reset is asserted.
    always_comb begin
        resp_ok  = c_resp_valid &&
                   ((state == ARB_WAIT) || ((state == ARB_ISSUE) && c_req_ready));
        resp_to  = TO_EN && (state == ARB_WAIT) && !c_resp_valid && (timer == T_LAST);
        owner_oh = NUM_REQ'(1) << grant_id;

        r_req_ready = '0;
        if ((state == ARB_IDLE) && pick_any && rst_n) begin
            r_req_ready = NUM_REQ'(1) << pick_idx;
        end

        r_resp_valid = (resp_ok || resp_to) ? owner_oh : '0;
        r_resp_rdata = resp_ok ? c_resp_rdata : '0;
        r_resp_err   = resp_to;
    end

    // Cache-side request is driven purely from state and hold registers.
    always_comb begin
        c_req_valid = (state == ARB_ISSUE);
        c_req_addr  = hold_addr;
        c_req_wdata = hold_wdata;
        c_req_write = hold_write;
        c_req_size  = hold_size;
        busy        = (state != ARB_IDLE);
    end

    // Arbitration FSM: grant in IDLE, hold request in ISSUE, wait for the
    // response (or time out) in WAIT, swallow a late response in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_write <= 1'b0;
            hold_size  <= '0;
            timer      <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        hold_addr  <= r_req_addr[pick_idx*ADDR_LENGTH +: ADDR_LENGTH];
                        hold_wdata <= r_req_wdata[pick_idx*WORD_SIZE +: WORD_SIZE];
                        hold_write <= r_req_write[pick_idx];
                        hold_size  <= r_req_size[pick_idx*3 +: 3];
                        grant_id   <= pick_idx;
                        rr_ptr     <= (pick_idx == GW'(NUM_REQ - 1)) ? '0 : pick_idx + GW'(1);
                        state      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (c_req_ready) begin
                        timer <= '0;
                        state <= c_resp_valid ? ARB_IDLE : ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (c_resp_valid) begin
                        state <= ARB_IDLE;
                    end else if (resp_to) begin
                        state <= ARB_DRAIN;
                    end else if (TO_EN && (timer != '1)) begin
                        timer <= timer + TW'(1);
                    end
                end
                ARB_DRAIN: begin
                    if (c_resp_valid) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Randomized scoreboard bench for dcache_req_arbiter (3 requesters, timeout 4).
module tb_dcache_req_arbiter;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int A  = 8;
    localparam int T  = 4;
    localparam int GW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     r_req_valid, r_req_write, r_req_ready, r_resp_valid;
    logic [N*A-1:0]   r_req_addr;
    logic [N*W-1:0]   r_req_wdata;
    logic [N*3-1:0]   r_req_size;
    logic [W-1:0]     r_resp_rdata;
    logic             r_resp_err;
    logic             c_req_valid;
    logic [A-1:0]     c_req_addr;
    logic [W-1:0]     c_req_wdata;
    logic             c_req_write;
    logic [2:0]       c_req_size;
    logic             c_req_ready, c_resp_valid;
    logic [W-1:0]     c_resp_rdata;
    logic             busy;
    logic [GW-1:0]    grant_id;

    dcache_req_arbiter #(
        .NUM_REQ        (N),
        .WORD_SIZE      (W),
        .ADDR_LENGTH    (A),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r_req_valid  (r_req_valid),
        .r_req_addr   (r_req_addr),
        .r_req_wdata  (r_req_wdata),
        .r_req_write  (r_req_write),
        .r_req_size   (r_req_size),
        .r_req_ready  (r_req_ready),
        .r_resp_valid (r_resp_valid),
        .r_resp_rdata (r_resp_rdata),
        .r_resp_err   (r_resp_err),
        .c_req_valid  (c_req_valid),
        .c_req_addr   (c_req_addr),
        .c_req_wdata  (c_req_wdata),
        .c_req_write  (c_req_write),
        .c_req_size   (c_req_size),
        .c_req_ready  (c_req_ready),
        .c_resp_valid (c_resp_valid),
        .c_resp_rdata (c_resp_rdata),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [A-1:0] addr;
        logic [W-1:0] wdata;
        logic         write;
        logic [2:0]   size;
    } creq_t;

    typedef struct {
        int           owner;
        logic [W-1:0] data;
        logic         err;
        int           cyc;
    } resp_t;

    creq_t creq_q[$];
    resp_t resp_q[$];
    int    own_q[$];

    // requester-side stimulus
    logic         q_val   [N];
    logic [A-1:0] q_addr  [N];
    logic [W-1:0] q_wdata [N];
    logic         q_write [N];
    logic [2:0]   q_size  [N];

    // cache-side behaviour
    int           c_cnt;
    int           c_stall;
    bit           c_seen;
    logic [W-1:0] c_data;

    // reference model of arbiter ownership
    bit m_busy, m_hs;
    int m_ptr, m_owner;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 11));
        return (r <= 8) ? r / 2 : r - 4;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            r_req_valid[i]          = q_val[i];
            r_req_write[i]          = q_write[i];
            r_req_addr[i*A +: A]    = q_addr[i];
            r_req_wdata[i*W +: W]   = q_wdata[i];
            r_req_size[i*3 +: 3]    = q_size[i];
        end
    endtask

    task automatic new_req(input int i);
        q_val[i]   = 1'b1;
        q_addr[i]  = A'($urandom);
        q_wdata[i] = W'($urandom);
        q_write[i] = 1'($urandom_range(0, 1));
        q_size[i]  = 3'($urandom_range(0, 2));
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) q_val[i] = 1'b0;
        c_cnt = 0; c_stall = 0; c_seen = 0;
        c_req_ready = 1'b0; c_resp_valid = 1'b0; c_resp_rdata = '0;
        creq_q.delete(); resp_q.delete(); own_q.delete();
        m_busy = 0; m_hs = 0; m_ptr = 0; m_owner = 0;
        pack();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},        32'(busy),         0);
        chk({tag, "_c_req_valid"}, 32'(c_req_valid),  0);
        chk({tag, "_r_req_ready"}, 32'(r_req_ready),  0);
        chk({tag, "_r_resp_valid"},32'(r_resp_valid), 0);
        chk({tag, "_r_resp_err"},  32'(r_resp_err),   0);
        chk({tag, "_r_resp_rdata"},32'(r_resp_rdata), 0);
        chk({tag, "_grant_id"},    32'(grant_id),     0);
        chk({tag, "_c_req_addr"},  32'(c_req_addr),   0);
    endtask

    // One cycle of requester and cache behaviour, driven just after the edge.
    task automatic drive_cycle(input bit allow_new);
        logic [N-1:0] rdy_s;
        resp_t        er;
        int           lat;
        @(negedge clk);
        rdy_s = r_req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rdy_s[i]) q_val[i] = 1'b0;
            if (!q_val[i] && allow_new && $urandom_range(0, 2) == 0) new_req(i);
        end
        c_req_ready  = 1'b0;
        c_resp_valid = 1'b0;
        c_resp_rdata = W'($urandom);
        if (c_cnt > 0) begin
            c_cnt--;
            if (c_cnt == 0) begin
                c_resp_valid = 1'b1;
                c_resp_rdata = c_data;
            end
        end else if (c_req_valid) begin
            if (!c_seen) begin
                c_seen  = 1;
                c_stall = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 2));
            end
            if (c_stall > 0) begin
                c_stall--;
            end else begin
                c_seen      = 0;
                c_req_ready = 1'b1;
                c_data      = W'($urandom);
                lat         = pick_lat();
                er.owner    = (own_q.size() > 0) ? own_q.pop_front() : -1;
                er.err      = (lat > T);
                er.data     = er.err ? '0 : c_data;
                er.cyc      = cyc + ((lat > T) ? T : lat);
                resp_q.push_back(er);
                if (lat == 0) begin
                    c_resp_valid = 1'b1;
                    c_resp_rdata = c_data;
                end else begin
                    c_cnt = lat;
                end
            end
        end else if ($urandom_range(0, 7) == 0) begin
            c_resp_valid = 1'b1;
        end
        pack();
    endtask

    // Monitor: predicts grants, checks cache payload and routed responses.
    always @(negedge clk) begin : mon
        logic [N-1:0] exp_rdy;
        logic [N-1:0] oh;
        int           w;
        creq_t        cr;
        resp_t        er;
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("c_req_valid", 32'(c_req_valid), 32'(m_busy && !m_hs));
            if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_owner));

            exp_rdy = '0;
            w = -1;
            if (!m_busy) begin
                w = pick(r_req_valid, m_ptr);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            chk("r_req_ready", 32'(r_req_ready), 32'(exp_rdy));
            if (w >= 0) begin
                cr.addr  = q_addr[w];
                cr.wdata = q_wdata[w];
                cr.write = q_write[w];
                cr.size  = q_size[w];
                creq_q.push_back(cr);
                own_q.push_back(w);
                m_ptr   = (w + 1) % N;
                m_busy  = 1;
                m_hs    = 0;
                m_owner = w;
            end

            if (c_req_valid) begin
                if (creq_q.size() == 0) begin
                    note_fail("c_req_unexpected");
                end else begin
                    chk("c_req_addr",  32'(c_req_addr),  32'(creq_q[0].addr));
                    chk("c_req_wdata", 32'(c_req_wdata), 32'(creq_q[0].wdata));
                    chk("c_req_write", 32'(c_req_write), 32'(creq_q[0].write));
                    chk("c_req_size",  32'(c_req_size),  32'(creq_q[0].size));
                    if (c_req_ready) begin
                        void'(creq_q.pop_front());
                        m_hs = 1;
                    end
                end
            end

            if (m_busy && m_hs && c_resp_valid) m_busy = 0;

            if (r_resp_valid != '0) begin
                if (resp_q.size() == 0) begin
                    note_fail("r_resp_unexpected");
                end else begin
                    er = resp_q.pop_front();
                    oh = '0;
                    if (er.owner >= 0) oh[er.owner] = 1'b1;
                    chk("r_resp_valid", 32'(r_resp_valid), 32'(oh));
                    chk("r_resp_rdata", 32'(r_resp_rdata), 32'(er.data));
                    chk("r_resp_err",   32'(r_resp_err),   32'(er.err));
                    chk("r_resp_cycle", 32'(cyc),          32'(er.cyc));
                end
            end else begin
                chk("idle_rdata", 32'(r_resp_rdata), 0);
                chk("idle_err",   32'(r_resp_err),   0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        note_fail("watchdog_timeout");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit found;
        clear_all();
        #3;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (3000) drive_cycle(1);

        // Reset while a response is outstanding.
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            drive_cycle(1);
            if (busy && !c_req_valid && c_cnt > 0) found = 1;
        end
        if (!found) note_fail("reach_wait_state");
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        clear_all();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) new_req(i);
        pack();

        repeat (1500) drive_cycle(1);

        // Let outstanding work finish without new requests.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            drive_cycle(0);
            if (!m_busy && c_cnt == 0 && !q_val[0] && !q_val[1] && !q_val[2]) found = 1;
        end
        if (!found) note_fail("drain_timeout");
        repeat (2) @(posedge clk);
        chk("creq_q_empty", 32'(creq_q.size()), 0);
        chk("resp_q_empty", 32'(resp_q.size()), 0);
        chk("own_q_empty",  32'(own_q.size()),  0);
        chk("final_busy",   32'(busy),          0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
